// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and flow control for a five-stage in-order pipeline.
// It drives the stage-register enables and bubble selects from the memory
// handshakes, load-use and branch hazards, and a small fetch FSM. That FSM
// discards the stale instruction-fetch response that follows a redirect.
// It also provides a sticky data-memory watchdog and saturating counters.
module pipeline_ctrl #(
    parameter int REG_W  = 5,
    parameter int CNT_W  = 32,
    parameter int WDOG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_read,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             branch_taken,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             bubble_if_id,
    output logic             bubble_id_ex,
    output logic             bubble_mem_wb,
    output logic             drop_imem_resp,
    output logic             timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] loaduse_cnt
);

    typedef enum logic [0:0] {
        F_IDLE    = 1'b0,
        F_DISCARD = 1'b1
    } fstate_t;

    localparam logic [WDOG_W-1:0] WDOG_LIMIT = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    fstate_t           fstate;
    logic [WDOG_W-1:0] wdog;

    logic dmem_stall;
    logic br;
    logic lu;
    logic rs1_hit;
    logic rs2_hit;
    logic fetch_wait;
    logic discarding;

    // Saturating increment shared by the performance counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                 input logic             en);
        if (en && (value != CNT_MAX)) begin
            return value + CNT_W'(1);
        end
        return value;
    endfunction

    // Hazard detection. A data-memory stall freezes the whole front end,
    // so it masks branches and load-use hazards. A branch held in the frozen
    // EX stage therefore acts only in the cycle the stall releases.
    assign dmem_stall = dmem_req & ~dmem_resp;
    assign br         = branch_taken & ~dmem_stall;
    assign rs1_hit    = id_use_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit    = id_use_rs2 & (id_rs2 == ex_rd);
    assign lu         = ex_valid & ex_is_load & (ex_rd != '0) &
                        (rs1_hit | rs2_hit) & ~dmem_stall & ~br;
    assign fetch_wait = imem_read & ~imem_resp;
    assign discarding = (fstate == F_DISCARD);

    // Stage enables and bubble selects, in priority order: reset, memory
    // stall, branch, load-use, fetch hold (waiting or discarding), free run.
    always_comb begin
        load_pc        = 1'b1;
        load_if_id     = 1'b1;
        load_id_ex     = 1'b1;
        load_ex_mem    = 1'b1;
        load_mem_wb    = 1'b1;
        bubble_if_id   = 1'b0;
        bubble_id_ex   = 1'b0;
        bubble_mem_wb  = 1'b0;
        drop_imem_resp = 1'b0;
        if (rst) begin
            load_pc       = 1'b0;
            load_if_id    = 1'b0;
            load_id_ex    = 1'b0;
            load_ex_mem   = 1'b0;
            load_mem_wb   = 1'b0;
            bubble_if_id  = 1'b1;
            bubble_id_ex  = 1'b1;
            bubble_mem_wb = 1'b1;
        end else begin
            // A stale response is discarded whenever it arrives after a
            // redirect, even while the back end is frozen.
            drop_imem_resp = discarding & imem_resp;
            if (dmem_stall) begin
                load_pc       = 1'b0;
                load_if_id    = 1'b0;
                load_id_ex    = 1'b0;
                load_ex_mem   = 1'b0;
                bubble_mem_wb = 1'b1;
            end else if (br) begin
                bubble_if_id = 1'b1;
                bubble_id_ex = 1'b1;
            end else if (lu) begin
                load_pc      = 1'b0;
                load_if_id   = 1'b0;
                bubble_id_ex = 1'b1;
            end else if (fetch_wait || discarding) begin
                load_pc      = 1'b0;
                bubble_if_id = 1'b1;
            end
        end
    end

    // Fetch FSM: after a redirect with a fetch in flight, wait for and
    // discard the stale response. A further branch keeps it waiting, and a
    // response in the same cycle as a branch ends the wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            fstate <= F_IDLE;
        end else begin
            case (fstate)
                F_IDLE: begin
                    if (br && fetch_wait) begin
                        fstate <= F_DISCARD;
                    end
                end
                F_DISCARD: begin
                    if (imem_resp) begin
                        fstate <= F_IDLE;
                    end
                end
                default: fstate <= F_IDLE;
            endcase
        end
    end

    // Watchdog: count consecutive memory-stall cycles and latch timeout at
    // the limit. After that, both the count and the flag hold until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog    <= '0;
            timeout <= 1'b0;
        end else if (!timeout) begin
            if (dmem_stall) begin
                wdog <= wdog + WDOG_W'(1);
                if (wdog == WDOG_LIMIT - WDOG_W'(1)) begin
                    timeout <= 1'b1;
                end
            end else begin
                wdog <= '0;
            end
        end
    end

    // Performance counters, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            loaduse_cnt <= '0;
        end else begin
            stall_cnt   <= sat_inc(stall_cnt, dmem_stall | lu);
            flush_cnt   <= sat_inc(flush_cnt, br);
            loaduse_cnt <= sat_inc(loaduse_cnt, lu);
        end
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 5, register-index width.
REQ-002 SHALL have parameter CNT_W, default 32, performance-counter width.
REQ-003 SHALL have parameter WDOG_W, default 8, dmem-stall watchdog counter width; the timeout limit is 2^WDOG_W-1 cycles.
REQ-004 clk input 1 clock; all state SHALL update on rising edge.
REQ-005 rst input 1 reset, synchronous, active-high.
REQ-006 imem_read input 1 fetch request outstanding.
REQ-007 imem_resp input 1 fetch data valid this cycle.
REQ-008 dmem_req input 1 EX/MEM stage holds a load or store.
REQ-009 dmem_resp input 1 data memory done this cycle.
REQ-010 id_rs1, id_rs2 input REG_W source registers of the instruction in ID.
REQ-011 id_use_rs1, id_use_rs2 input 1 the matching source register is read.
REQ-012 ex_valid, ex_is_load input 1 ID/EX holds a valid load.
REQ-013 ex_rd input REG_W destination register in ID/EX.
REQ-014 branch_taken input 1 EX redirects the PC.
REQ-015 load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb output 1 register enables.
REQ-016 bubble_if_id, bubble_id_ex, bubble_mem_wb output 1 load a zero or invalid entry instead of next-stage data.
REQ-017 drop_imem_resp output 1 discard the current fetch response.
REQ-018 timeout output 1 sticky dmem watchdog flag.
REQ-019 stall_cnt, flush_cnt, loaduse_cnt output CNT_W performance counters.

Function
REQ-020 dmem_stall = dmem_req & ~dmem_resp; SHALL be combinational, zero latency.
REQ-021 When dmem_stall is set: load_pc, load_if_id, load_id_ex and load_ex_mem = 0; load_mem_wb = 1 with bubble_mem_wb = 1; all other hazards are masked.
REQ-022 br = branch_taken & ~dmem_stall; a branch held in a frozen EX SHALL act in the cycle the stall releases.
REQ-023 Load-use: lu = ex_valid & ex_is_load & ex_rd != 0 & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)) & ~dmem_stall & ~br.
REQ-024 When lu is set: load_pc = 0, load_if_id = 0, load_id_ex = 1 with bubble_id_ex = 1, load_ex_mem = 1, load_mem_wb = 1.
REQ-025 When br is set: load_pc = 1, bubble_if_id = 1, bubble_id_ex = 1, and all load_* = 1; a branch overrides a load-use hazard in the same cycle.
REQ-026 Fetch wait (imem_read & ~imem_resp, no br, no dmem_stall): load_pc = 0, IF/ID loaded with bubble; downstream stages advance.
REQ-027 Fetch FSM states: F_IDLE and F_DISCARD; reset state is F_IDLE.
REQ-028 F_IDLE -> F_DISCARD when br & imem_read & ~imem_resp.
REQ-029 In F_DISCARD: drop_imem_resp = imem_resp, bubble_if_id = 1, load_pc = 0; the FSM returns to F_IDLE on imem_resp.
REQ-030 A br in F_DISCARD SHALL keep the FSM in F_DISCARD and load the PC; a br with imem_resp in the same cycle SHALL return to F_IDLE (the response is dropped via the bubble).
REQ-031 No hazard: all load_* = 1, all bubble_* = 0.
REQ-032 Watchdog: counts consecutive dmem_stall cycles and clears when dmem_stall = 0; at the limit, timeout = 1 until rst and the counter holds.
REQ-033 stall_cnt increments on each dmem_stall or lu cycle; flush_cnt on each br; loaduse_cnt on each lu; all counters saturate at all-ones.

Reset
REQ-034 During rst: all load_* = 0, all bubble_* = 1, drop_imem_resp = 0, FSM = F_IDLE, watchdog = 0, timeout = 0, counters = 0.
REQ-035 rst mid-stall or in F_DISCARD SHALL take effect on the next edge and leave no residual discard.

Verification
REQ-036 Load writes x5 in EX, ID reads x5 as rs1 -> one cycle with load_pc = 0, load_if_id = 0, bubble_id_ex = 1; loaduse_cnt = 1.
REQ-037 Same as REQ-036 but ex_rd = 0 -> no stall.
REQ-038 dmem_req held 3 cycles before dmem_resp -> 3 cycles of frozen front end with bubble_mem_wb = 1; stall_cnt = 3.
REQ-039 br while a fetch is outstanding, response 2 cycles later -> drop_imem_resp = 1 on that cycle, FSM back to F_IDLE, flush_cnt = 1.
REQ-040 br asserted during dmem_stall -> no flush until the stall releases, then exactly one flush.
REQ-041 WDOG_W = 3, dmem_req never acknowledged -> timeout = 1 after 7 cycles, sticky until rst.
